// File: rtl/mem_byte_bridge_if.sv
// mem_byte_bridge_if: CPU request bus and byte-wide controller port seen by mem_byte_bridge
// slave modport  = the bridge (takes CPU requests, drives the controller side)
// master modport = the surroundings (CPU issuing requests, controller answering bytes)
interface mem_byte_bridge_if;
  logic        i_req;
  logic        i_wr;
  logic        i_word;
  logic [25:0] i_addr;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic        o_mem_req;
  logic [25:0] o_mem_address;
  logic        o_mem_we;
  logic [7:0]  o_mem_data;
  logic [7:0]  i_mem_data;
  logic        i_mem_ready;
  modport slave (
    input  i_req, i_wr, i_word, i_addr, i_wdata, i_mem_data, i_mem_ready,
    output o_rdata, o_busy, o_done, o_error, o_mem_req, o_mem_address, o_mem_we, o_mem_data
  );
  modport master (
    output i_req, i_wr, i_word, i_addr, i_wdata, i_mem_data, i_mem_ready,
    input  o_rdata, o_busy, o_done, o_error, o_mem_req, o_mem_address, o_mem_we, o_mem_data
  );
endinterface

// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: splits 8/16-bit CPU accesses into sequential byte accesses on the memory controller port
// i_clock/i_reset : clock and asynchronous active-high reset
// bus (slave)     : CPU side i_req/i_wr/i_word/i_addr/i_wdata -> o_rdata/o_busy/o_done/o_error,
//                   controller side o_mem_req/o_mem_address/o_mem_we/o_mem_data <- i_mem_data/i_mem_ready
// Optional BRIDGE_TIMEOUT_EN: abort a byte after TIMEOUT_CYCLES cycles without ready and flag o_error.
module mem_byte_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              i_clock,
  input logic              i_reset,
  mem_byte_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LO_REQ, GAP, HI_REQ, DONE} state_t;
  state_t      state_q, state_d;
  logic        wr_q, wr_d, word_q, word_d, done_q, done_d, req_q, req_d;
  logic [7:0]  hi_q, hi_d, data_q, data_d;
  logic [25:0] addr_q, addr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        take;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  // req_q is only high in LO_REQ/HI_REQ, so ready elsewhere is ignored
  assign take = req_q & bus.i_mem_ready;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, expire;
  assign expire = req_q && !bus.i_mem_ready && cnt_q == CNT_MAX;
`endif
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    word_d  = word_q;
    hi_d    = hi_q;
    data_d  = data_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    done_d  = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    // counts while a byte is requested; every non-request state clears it, so each byte starts at 0
    cnt_d   = req_q ? cnt_q + 1'b1 : '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.i_req) begin
        state_d = LO_REQ;
        req_d   = 1'b1;
        wr_d    = bus.i_wr;
        word_d  = bus.i_word;
        addr_d  = bus.i_addr;
        data_d  = bus.i_wdata[7:0];
        hi_d    = bus.i_wdata[15:8];
        if (!bus.i_wr && !bus.i_word) rdata_d[15:8] = 8'h00;
      end
      LO_REQ: if (take) begin
        req_d   = 1'b0;
        state_d = word_q ? GAP : DONE;
        done_d  = !word_q;
        if (!wr_q) rdata_d[7:0] = bus.i_mem_data;
      end
      GAP: begin
        state_d = HI_REQ;
        req_d   = 1'b1;
        addr_d  = addr_q + 26'd1;
        data_d  = hi_q;
      end
      HI_REQ: if (take) begin
        req_d   = 1'b0;
        state_d = DONE;
        done_d  = 1'b1;
        if (!wr_q) rdata_d[15:8] = bus.i_mem_data;
      end
      default: state_d = IDLE;
    endcase
`ifdef BRIDGE_TIMEOUT_EN
    if (expire) begin
      state_d = DONE;
      req_d   = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
      rdata_d = '0;
    end
`endif
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      word_q  <= 1'b0;
      hi_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      done_q  <= done_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  assign bus.o_rdata       = rdata_q;
  assign bus.o_busy        = state_q != IDLE;
  assign bus.o_done        = done_q;
  assign bus.o_mem_req     = req_q;
  assign bus.o_mem_address = addr_q;
  assign bus.o_mem_we      = wr_q;
  assign bus.o_mem_data    = data_q;
`ifdef BRIDGE_TIMEOUT_EN
  assign bus.o_error       = err_q;
`else
  assign bus.o_error       = 1'b0;
`endif
endmodule
